// File: rtl/sw_bank_sequencer.sv
// Sequences one Smith-Waterman score bank from an upstream record stream: penalties, query, targets, end-of-query.
// Optional drain watchdog is built when SEQ_TIMEOUT_EN is defined.
module sw_bank_sequencer #(
  parameter int SCORE_WIDTH     = 12,
  parameter int PAYLOAD_WIDTH   = 48 + 12 + 256,
  parameter int MODULES         = 2,
  parameter int MAX_OUTSTANDING = 1024,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [1:0]                 s_kind,
  input  logic [PAYLOAD_WIDTH-1:0]   s_data,
  input  logic                       bank_full,
  input  logic [2*MODULES-1:0]       bank_vld,
  output logic                       ld_sequence,
  output logic                       ld_penalties,
  output logic [PAYLOAD_WIDTH+1:0]   data_out,
  output logic [4*SCORE_WIDTH-1:0]   penalties_out,
  output logic                       query_done,
  output logic                       busy,
  output logic                       timeout,
  output logic [1:0]                 state_dbg
);

  // Upstream handshake: a record transfers on any cycle where s_valid && s_ready;
  // s_valid/s_kind/s_data must hold steady while s_valid is high and s_ready is low.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    QUERY = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [1:0] K_PEN = 2'b00;
  localparam logic [1:0] K_QRY = 2'b01;
  localparam logic [1:0] K_TGT = 2'b10;
  localparam logic [1:0] K_EOQ = 2'b11;

  state_t        state, state_next;
  logic          done_next;
  logic [CW-1:0] outstanding, outstanding_next, vld_cnt;
  logic [CW:0]   cnt_sum;
  logic          hold;
  logic          accept;
  logic          wdog_fire;

  always_comb begin
    s_ready = 1'b0;
    if (rst) begin
      case (state)
        IDLE:    s_ready = (s_kind == K_PEN || s_kind == K_QRY) && (outstanding == '0);
        QUERY:   s_ready = (s_kind == K_EOQ) ||
                           (s_kind == K_TGT && !bank_full && !hold &&
                            outstanding < CW'(MAX_OUTSTANDING));
        default: s_ready = 1'b0;
      endcase
    end
  end

  assign accept = s_valid && s_ready;

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE:  if (accept && s_kind == K_QRY) state_next = QUERY;
      QUERY: if (accept && s_kind == K_EOQ) state_next = DRAIN;
      DRAIN: begin
        if (outstanding == '0 || wdog_fire) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // hold is high exactly in the target strobe cycle, so it also serves as the counter increment.
  always_comb begin
    vld_cnt = '0;
    for (int i = 0; i < 2 * MODULES; i++) vld_cnt = vld_cnt + CW'(bank_vld[i]);
    cnt_sum = {1'b0, outstanding} + (CW + 1)'(hold);
    if (wdog_fire || cnt_sum < {1'b0, vld_cnt}) outstanding_next = '0;
    else outstanding_next = CW'(cnt_sum - {1'b0, vld_cnt});
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      outstanding   <= '0;
      hold          <= 1'b0;
      ld_sequence   <= 1'b0;
      ld_penalties  <= 1'b0;
      data_out      <= '0;
      penalties_out <= '0;
      query_done    <= 1'b0;
    end else begin
      state        <= state_next;
      outstanding  <= outstanding_next;
      query_done   <= done_next;
      hold         <= accept && s_kind == K_TGT;
      ld_sequence  <= accept && (s_kind == K_QRY || s_kind == K_TGT);
      ld_penalties <= accept && s_kind == K_PEN;
      if (accept && (s_kind == K_QRY || s_kind == K_TGT))
        data_out <= {s_kind == K_TGT, s_kind == K_QRY, s_data};
      if (accept && s_kind == K_PEN)
        penalties_out <= s_data[4*SCORE_WIDTH-1:0];
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wdog;
  logic          timeout_q;

  // Fires on the TIMEOUT_CYCLES-th consecutive strobe-free DRAIN cycle.
  assign wdog_fire = (state == DRAIN) && !(|bank_vld) && (wdog == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      wdog      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state != DRAIN || (|bank_vld) || wdog_fire) wdog <= '0;
      else wdog <= wdog + 1'b1;
      if (wdog_fire) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign wdog_fire = 1'b0;
  // No watchdog: the comparison is constant false, keeping timeout tied low.
  assign timeout   = (TIMEOUT_CYCLES < 0);
`endif

  assign busy      = (state != IDLE) || (outstanding != '0);
  assign state_dbg = state;

endmodule

// File: tb/tb_sw_bank_sequencer.sv
// Directed bench for sw_bank_sequencer: penalties, query/targets with full throttling, drain, counter corner cases.
module tb_sw_bank_sequencer;
  localparam int SW   = 12;
  localparam int PW   = 48 + 12 + 256;
  localparam int M    = 2;
  localparam int MAXO = 1024;
`ifdef SEQ_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 65535;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [1:0]    s_kind;
  logic [PW-1:0] s_data;
  logic          bank_full;
  logic [2*M-1:0] bank_vld;
  logic          ld_sequence;
  logic          ld_penalties;
  logic [PW+1:0] data_out;
  logic [4*SW-1:0] penalties_out;
  logic          query_done;
  logic          busy;
  logic          timeout;
  logic [1:0]    state_dbg;

  int vectors = 0;
  int miscompares = 0;

  logic [PW-1:0] pen_in, q1, q2, t1, t2, t3, t4, t5;
  logic [4*SW-1:0] pen_exp;

  sw_bank_sequencer #(
    .SCORE_WIDTH(SW), .PAYLOAD_WIDTH(PW), .MODULES(M),
    .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_kind(s_kind),
    .s_data(s_data), .bank_full(bank_full), .bank_vld(bank_vld),
    .ld_sequence(ld_sequence), .ld_penalties(ld_penalties), .data_out(data_out),
    .penalties_out(penalties_out), .query_done(query_done), .busy(busy),
    .timeout(timeout), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [PW+1:0] obs, input logic [PW+1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    pen_exp = 48'h002FFEFFDFFF;
    pen_in  = {{67{4'hA}}, pen_exp};
    q1 = {79{4'h1}};
    q2 = {79{4'h6}};
    t1 = {79{4'h2}};
    t2 = {79{4'h3}};
    t3 = {79{4'h4}};
    t4 = {79{4'h5}};
    t5 = {79{4'h7}};

    rst = 1'b0; s_valid = 1'b0; s_kind = 2'b00; s_data = '0;
    bank_full = 1'b0; bank_vld = '0;
    repeat (3) tick();
    chk("rst_ld_sequence", ld_sequence, 0);
    chk("rst_ld_penalties", ld_penalties, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_penalties_out", penalties_out, 0);
    chk("rst_query_done", query_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_state", state_dbg, 0);
    chk("rst_s_ready", s_ready, 0);
    rst = 1'b1;
    tick();

    // penalties
    s_valid = 1'b1; s_kind = 2'b00; s_data = pen_in; #1;
    chk("pen_ready", s_ready, 1);
    tick();
    chk("pen_strobe", ld_penalties, 1);
    chk("pen_value", penalties_out, pen_exp);
    chk("pen_no_seq", ld_sequence, 0);
    chk("pen_ready_after", s_ready, 1);
    s_valid = 1'b0;
    tick();
    chk("pen_strobe_end", ld_penalties, 0);
    chk("pen_held", penalties_out, pen_exp);

    // query then targets
    s_valid = 1'b1; s_kind = 2'b01; s_data = q1; #1;
    chk("q_ready", s_ready, 1);
    tick();
    chk("q_strobe", ld_sequence, 1);
    chk("q_data", data_out, {2'b01, q1});
    chk("q_state", state_dbg, 1);
    s_kind = 2'b10; s_data = t1; #1;
    chk("t1_ready", s_ready, 1);
    tick();
    chk("t1_strobe", ld_sequence, 1);
    chk("t1_data", data_out, {2'b10, t1});
    s_data = t2; #1;
    chk("t2_hold_ready", s_ready, 0);
    tick();
    chk("t2_gap_strobe", ld_sequence, 0);
    chk("t2_out1", dut.outstanding, 1);
    chk("t2_ready", s_ready, 1);
    tick();
    chk("t2_strobe", ld_sequence, 1);
    chk("t2_data", data_out, {2'b10, t2});
    bank_full = 1'b1; s_data = t3;
    tick();
    chk("full_strobe", ld_sequence, 0);
    chk("full_out2", dut.outstanding, 2);
    chk("full_ready", s_ready, 0);
    tick();
    chk("full_ready2", s_ready, 0);
    chk("full_strobe2", ld_sequence, 0);
    bank_full = 1'b0; #1;
    chk("release_ready", s_ready, 1);
    tick();
    chk("t3_strobe", ld_sequence, 1);
    chk("t3_data", data_out, {2'b10, t3});
    s_valid = 1'b0;
    tick();
    chk("out3", dut.outstanding, 3);
    chk("busy_q", busy, 1);

    // end of query and drain
    s_valid = 1'b1; s_kind = 2'b11; #1;
    chk("eoq_ready", s_ready, 1);
    tick();
    chk("eoq_state", state_dbg, 2);
    chk("eoq_no_strobe", ld_sequence, 0);
    s_kind = 2'b01; s_data = q2; bank_vld = 4'b0101; #1;
    chk("drain_q_stall", s_ready, 0);
    tick();
    chk("drain_out1", dut.outstanding, 1);
    bank_vld = 4'b1000;
    tick();
    chk("drain_out0", dut.outstanding, 0);
    chk("drain_state", state_dbg, 2);
    chk("drain_no_done", query_done, 0);
    bank_vld = '0; #1;
    chk("drain_q_stall2", s_ready, 0);
    tick();
    chk("done_pulse", query_done, 1);
    chk("done_idle", state_dbg, 0);
    chk("done_q_ready", s_ready, 1);
    tick();
    chk("done_end", query_done, 0);
    chk("q2_strobe", ld_sequence, 1);
    chk("q2_data", data_out, {2'b01, q2});
    chk("q2_state", state_dbg, 1);

    // simultaneous increment and decrement, then saturation at zero
    s_kind = 2'b10; s_data = t4;
    tick();
    chk("t4_strobe", ld_sequence, 1);
    s_valid = 1'b0; s_data = t5;
    tick();
    chk("t4_out1", dut.outstanding, 1);
    s_valid = 1'b1;
    tick();
    chk("t5_strobe", ld_sequence, 1);
    s_valid = 1'b0; bank_vld = 4'b0010;
    tick();
    chk("net_out1", dut.outstanding, 1);
    bank_vld = 4'b0001;
    tick();
    chk("dec_out0", dut.outstanding, 0);
    bank_vld = 4'b1111;
    tick();
    chk("sat_out0", dut.outstanding, 0);
    chk("sat_busy", busy, 1);
    bank_vld = '0;

    // end of query with nothing outstanding
    s_valid = 1'b1; s_kind = 2'b11;
    tick();
    s_valid = 1'b0;
    chk("eoq0_drain", state_dbg, 2);
    chk("eoq0_no_done", query_done, 0);
    tick();
    chk("eoq0_idle", state_dbg, 0);
    chk("eoq0_done", query_done, 1);
    tick();
    chk("eoq0_done_end", query_done, 0);
    chk("eoq0_busy", busy, 0);

    // reset mid-run abandons in-flight target
    s_valid = 1'b1; s_kind = 2'b01; s_data = q1;
    tick();
    s_kind = 2'b10; s_data = t1;
    tick();
    s_valid = 1'b0;
    tick();
    chk("mid_out1", dut.outstanding, 1);
    rst = 1'b0;
    tick();
    chk("mid_rst_out", dut.outstanding, 0);
    chk("mid_rst_state", state_dbg, 0);
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_pen", penalties_out, 0);
    rst = 1'b1; bank_vld = 4'b0011;
    tick();
    chk("mid_late_vld", dut.outstanding, 0);
    bank_vld = '0;

`ifdef SEQ_TIMEOUT_EN
    s_valid = 1'b1; s_kind = 2'b01; s_data = q1;
    tick();
    s_kind = 2'b10; s_data = t1;
    tick();
    s_kind = 2'b11;
    tick();
    s_valid = 1'b0;
    chk("to_drain", state_dbg, 2);
    chk("to_out1", dut.outstanding, 1);
    repeat (15) tick();
    chk("to_not_yet", timeout, 0);
    chk("to_still_drain", state_dbg, 2);
    tick();
    chk("to_set", timeout, 1);
    chk("to_done", query_done, 1);
    chk("to_idle", state_dbg, 0);
    chk("to_out0", dut.outstanding, 0);
    tick();
    chk("to_sticky", timeout, 1);
    chk("to_done_end", query_done, 0);
`else
    chk("no_wdog_timeout", timeout, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
